// File: rtl/rvx_core_trap_sequencer_pkg.sv
// Shared constants for the trap sequencer: cause codes, PC mux selects, state encodings.
// Optional vectored-offset feature is controlled by RVX_TRAP_VECTORED_EN in the top module.
package rvx_core_trap_sequencer_pkg;

    localparam logic [3:0] RVX_CAUSE_MISALIGNED_FETCH = 4'd0;
    localparam logic [3:0] RVX_CAUSE_ILLEGAL          = 4'd2;
    localparam logic [3:0] RVX_CAUSE_BREAKPOINT       = 4'd3;
    localparam logic [3:0] RVX_CAUSE_MISALIGNED_LOAD  = 4'd4;
    localparam logic [3:0] RVX_CAUSE_MISALIGNED_STORE = 4'd6;
    localparam logic [3:0] RVX_CAUSE_ECALL_M          = 4'd11;
    localparam logic [3:0] RVX_CAUSE_IRQ_MSI          = 4'd3;
    localparam logic [3:0] RVX_CAUSE_IRQ_MTI          = 4'd7;
    localparam logic [3:0] RVX_CAUSE_IRQ_MEI          = 4'd11;

    localparam logic [1:0] RVX_PC_NEXT = 2'b00;
    localparam logic [1:0] RVX_PC_TRAP = 2'b01;
    localparam logic [1:0] RVX_PC_MEPC = 2'b10;
    localparam logic [1:0] RVX_PC_BOOT = 2'b11;

    localparam logic [2:0] RVX_TRAP_STATE_RESET       = 3'd0;
    localparam logic [2:0] RVX_TRAP_STATE_OPERATING   = 3'd1;
    localparam logic [2:0] RVX_TRAP_STATE_TRAP_WAIT   = 3'd2;
    localparam logic [2:0] RVX_TRAP_STATE_TRAP_TAKEN  = 3'd3;
    localparam logic [2:0] RVX_TRAP_STATE_TRAP_RETURN = 3'd4;

    typedef struct packed {
        logic       valid;
        logic       irq;
        logic [3:0] code;
    } trap_cause_t;

    function automatic logic [31:0] make_mcause(input logic irq, input logic [3:0] code);
        return {irq, 27'b0, code};
    endfunction

endpackage

// File: rtl/rvx_core_interrupt_prioritizer.sv
// Picks the highest-priority enabled machine interrupt (MEI > MSI > MTI).
module rvx_core_interrupt_prioritizer
    import rvx_core_trap_sequencer_pkg::*;
(
    input  logic       mstatus_mie,
    input  logic [2:0] mie,
    input  logic [2:0] mip,
    output logic       irq,
    output logic [3:0] code
);

    logic [2:0] pending;

    assign pending = mie & mip;
    assign irq     = mstatus_mie & (|pending);

    // bit order is {MEI, MTI, MSI}; MSI outranks MTI despite its lower bit position
    always_comb begin
        code = 4'd0;
        if (pending[2]) begin
            code = RVX_CAUSE_IRQ_MEI;
        end else if (pending[0]) begin
            code = RVX_CAUSE_IRQ_MSI;
        end else if (pending[1]) begin
            code = RVX_CAUSE_IRQ_MTI;
        end
    end

endmodule

// File: rtl/rvx_core_trap_sequencer.sv
// Trap/return sequencer: selects cause, drains the bus, then steers PC mux, flush/stall and CSR strobes.
// Define RVX_TRAP_VECTORED_EN to drive trap_vector_offset for vectored interrupts.
module rvx_core_trap_sequencer
    import rvx_core_trap_sequencer_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        illegal_instruction_s1,
    input  logic        ecall_s1,
    input  logic        ebreak_s1,
    input  logic        mret_s1,
    input  logic        misaligned_instruction_s1,
    input  logic        misaligned_load_s1,
    input  logic        misaligned_store_s1,
    input  logic        mstatus_mie,
    input  logic [2:0]  mie,
    input  logic [2:0]  mip,
    input  logic        bus_busy,
    input  logic        mtvec_mode,
    output logic [1:0]  pc_mux_sel,
    output logic        flush_s1,
    output logic        stall_s1,
    output logic        trap_taken,
    output logic        mret_taken,
    output logic [31:0] mcause,
    output logic [31:0] trap_vector_offset
);

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic        irq;
    logic [3:0]  irq_code;
    trap_cause_t cause;
    logic        mret_event;

    rvx_core_interrupt_prioritizer u_prioritizer (
        .mstatus_mie (mstatus_mie),
        .mie         (mie),
        .mip         (mip),
        .irq         (irq),
        .code        (irq_code)
    );

    always_comb begin
        cause = '0;
        if (irq) begin
            cause = '{valid: 1'b1, irq: 1'b1, code: irq_code};
        end else if (misaligned_instruction_s1) begin
            cause = '{valid: 1'b1, irq: 1'b0, code: RVX_CAUSE_MISALIGNED_FETCH};
        end else if (illegal_instruction_s1) begin
            cause = '{valid: 1'b1, irq: 1'b0, code: RVX_CAUSE_ILLEGAL};
        end else if (ebreak_s1) begin
            cause = '{valid: 1'b1, irq: 1'b0, code: RVX_CAUSE_BREAKPOINT};
        end else if (ecall_s1) begin
            cause = '{valid: 1'b1, irq: 1'b0, code: RVX_CAUSE_ECALL_M};
        end else if (misaligned_load_s1) begin
            cause = '{valid: 1'b1, irq: 1'b0, code: RVX_CAUSE_MISALIGNED_LOAD};
        end else if (misaligned_store_s1) begin
            cause = '{valid: 1'b1, irq: 1'b0, code: RVX_CAUSE_MISALIGNED_STORE};
        end
    end

    // an interrupt arriving with an MRET wins; the MRET's own PC ends up in mepc
    assign mret_event = mret_s1 & ~cause.valid;

    always_comb begin
        state_next = state;
        case (state)
            RVX_TRAP_STATE_RESET:       state_next = RVX_TRAP_STATE_OPERATING;
            RVX_TRAP_STATE_OPERATING: begin
                if (cause.valid) begin
                    state_next = bus_busy ? RVX_TRAP_STATE_TRAP_WAIT : RVX_TRAP_STATE_TRAP_TAKEN;
                end else if (mret_event) begin
                    state_next = RVX_TRAP_STATE_TRAP_RETURN;
                end
            end
            RVX_TRAP_STATE_TRAP_WAIT: begin
                if (!bus_busy) begin
                    state_next = RVX_TRAP_STATE_TRAP_TAKEN;
                end
            end
            RVX_TRAP_STATE_TRAP_TAKEN:  state_next = RVX_TRAP_STATE_OPERATING;
            RVX_TRAP_STATE_TRAP_RETURN: state_next = RVX_TRAP_STATE_OPERATING;
            default:                    state_next = RVX_TRAP_STATE_RESET;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= RVX_TRAP_STATE_RESET;
            mcause <= 32'd0;
        end else begin
            state <= state_next;
            if (state == RVX_TRAP_STATE_OPERATING && cause.valid) begin
                mcause <= make_mcause(cause.irq, cause.code);
            end
        end
    end

    always_comb begin
        pc_mux_sel = RVX_PC_NEXT;
        flush_s1   = 1'b0;
        stall_s1   = 1'b0;
        trap_taken = 1'b0;
        mret_taken = 1'b0;
        case (state)
            RVX_TRAP_STATE_RESET: begin
                pc_mux_sel = RVX_PC_BOOT;
                flush_s1   = 1'b1;
            end
            RVX_TRAP_STATE_TRAP_WAIT: begin
                stall_s1 = 1'b1;
            end
            RVX_TRAP_STATE_TRAP_TAKEN: begin
                pc_mux_sel = RVX_PC_TRAP;
                flush_s1   = 1'b1;
                trap_taken = 1'b1;
            end
            RVX_TRAP_STATE_TRAP_RETURN: begin
                pc_mux_sel = RVX_PC_MEPC;
                flush_s1   = 1'b1;
                mret_taken = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // BOOT_ADDRESS is applied by the fetch PC mux when pc_mux_sel selects boot
    logic unused_inputs;

`ifdef RVX_TRAP_VECTORED_EN
    assign trap_vector_offset = (mcause[31] && mtvec_mode) ? {26'b0, mcause[3:0], 2'b00} : 32'd0;
    assign unused_inputs      = ^BOOT_ADDRESS;
`else
    assign trap_vector_offset = 32'd0;
    assign unused_inputs      = mtvec_mode ^ (^BOOT_ADDRESS);
`endif

endmodule

// File: tb/tb_rvx_core_trap_sequencer.sv
// Scoreboard bench for rvx_core_trap_sequencer: expected outputs queued with each stimulus step.
module tb_rvx_core_trap_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        illegal_instruction_s1, ecall_s1, ebreak_s1, mret_s1;
    logic        misaligned_instruction_s1, misaligned_load_s1, misaligned_store_s1;
    logic        mstatus_mie;
    logic [2:0]  mie, mip;
    logic        bus_busy, mtvec_mode;
    logic [1:0]  pc_mux_sel;
    logic        flush_s1, stall_s1, trap_taken, mret_taken;
    logic [31:0] mcause, trap_vector_offset;

`ifdef RVX_TRAP_VECTORED_EN
    localparam logic [31:0] VEC_MEI = 32'h0000002C;
`else
    localparam logic [31:0] VEC_MEI = 32'h00000000;
`endif

    typedef struct packed {
        logic [1:0]  pc;
        logic        flush;
        logic        stall;
        logic        tt;
        logic        mt;
        logic [31:0] mc;
        logic [31:0] off;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    rvx_core_trap_sequencer #(.BOOT_ADDRESS(32'h00000000)) dut (
        .clock                     (clock),
        .reset                     (reset),
        .illegal_instruction_s1    (illegal_instruction_s1),
        .ecall_s1                  (ecall_s1),
        .ebreak_s1                 (ebreak_s1),
        .mret_s1                   (mret_s1),
        .misaligned_instruction_s1 (misaligned_instruction_s1),
        .misaligned_load_s1        (misaligned_load_s1),
        .misaligned_store_s1       (misaligned_store_s1),
        .mstatus_mie               (mstatus_mie),
        .mie                       (mie),
        .mip                       (mip),
        .bus_busy                  (bus_busy),
        .mtvec_mode                (mtvec_mode),
        .pc_mux_sel                (pc_mux_sel),
        .flush_s1                  (flush_s1),
        .stall_s1                  (stall_s1),
        .trap_taken                (trap_taken),
        .mret_taken                (mret_taken),
        .mcause                    (mcause),
        .trap_vector_offset        (trap_vector_offset)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t idle(input logic [31:0] mc, input logic [31:0] off);
        return '{pc: 2'b00, flush: 1'b0, stall: 1'b0, tt: 1'b0, mt: 1'b0, mc: mc, off: off};
    endfunction

    function automatic exp_t boot();
        return '{pc: 2'b11, flush: 1'b1, stall: 1'b0, tt: 1'b0, mt: 1'b0, mc: 32'd0, off: 32'd0};
    endfunction

    function automatic exp_t waiting(input logic [31:0] mc);
        return '{pc: 2'b00, flush: 1'b0, stall: 1'b1, tt: 1'b0, mt: 1'b0, mc: mc, off: 32'd0};
    endfunction

    function automatic exp_t taken(input logic [31:0] mc, input logic [31:0] off);
        return '{pc: 2'b01, flush: 1'b1, stall: 1'b0, tt: 1'b1, mt: 1'b0, mc: mc, off: off};
    endfunction

    function automatic exp_t returning(input logic [31:0] mc);
        return '{pc: 2'b10, flush: 1'b1, stall: 1'b0, tt: 1'b0, mt: 1'b1, mc: mc, off: 32'd0};
    endfunction

    task automatic compare_front();
        exp_t  e;
        string t;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check_eq({t, ".pc"},    {30'd0, pc_mux_sel}, {30'd0, e.pc});
        check_eq({t, ".flush"}, {31'd0, flush_s1},   {31'd0, e.flush});
        check_eq({t, ".stall"}, {31'd0, stall_s1},   {31'd0, e.stall});
        check_eq({t, ".trap"},  {31'd0, trap_taken}, {31'd0, e.tt});
        check_eq({t, ".mret"},  {31'd0, mret_taken}, {31'd0, e.mt});
        check_eq({t, ".mcause"}, mcause, e.mc);
        check_eq({t, ".offset"}, trap_vector_offset, e.off);
        check_eq({t, ".excl"}, {31'd0, stall_s1 & flush_s1}, 32'd0);
    endtask

    // expectation for the cycle following the next rising edge
    task automatic tick(input string tag, input exp_t e);
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
        compare_front();
    endtask

    task automatic sample_now(input string tag, input exp_t e);
        sb_q.push_back(e);
        tag_q.push_back(tag);
        compare_front();
    endtask

    task automatic clear_flags();
        illegal_instruction_s1    = 1'b0;
        ecall_s1                  = 1'b0;
        ebreak_s1                 = 1'b0;
        mret_s1                   = 1'b0;
        misaligned_instruction_s1 = 1'b0;
        misaligned_load_s1        = 1'b0;
        misaligned_store_s1       = 1'b0;
        mip                       = 3'b000;
    endtask

    task automatic single_trap(input string tag, input logic [31:0] mc);
        tick({tag, "_take"}, taken(mc, 32'd0));
        clear_flags();
        tick({tag, "_idle"}, idle(mc, 32'd0));
    endtask

    initial begin
        reset       = 1'b1;
        clear_flags();
        mstatus_mie = 1'b0;
        mie         = 3'b000;
        bus_busy    = 1'b0;
        mtvec_mode  = 1'b0;

        // reset: held RESET shows boot select, then exactly one step into OPERATING
        tick("rst_hold", boot());
        reset = 1'b0;
        #1;
        sample_now("rst_release", boot());
        tick("rst_oper", idle(32'd0, 32'd0));
        tick("rst_oper2", idle(32'd0, 32'd0));

        // illegal, no drain; flags during TRAP_TAKEN are ignored
        illegal_instruction_s1 = 1'b1;
        tick("illegal_take", taken(32'h2, 32'd0));
        illegal_instruction_s1 = 1'b0;
        ecall_s1 = 1'b1;
        tick("illegal_ignore", idle(32'h2, 32'd0));
        ecall_s1 = 1'b0;
        tick("illegal_idle", idle(32'h2, 32'd0));

        // ecall under a busy bus: three stall cycles, then the trap
        ecall_s1 = 1'b1;
        bus_busy = 1'b1;
        tick("ecall_wait1", waiting(32'hB));
        ecall_s1 = 1'b0;
        tick("ecall_wait2", waiting(32'hB));
        tick("ecall_wait3", waiting(32'hB));
        bus_busy = 1'b0;
        tick("ecall_take", taken(32'hB, 32'd0));
        tick("ecall_idle", idle(32'hB, 32'd0));

        // MTIP+MSIP with concurrent mret: MSI wins, mret discarded
        mstatus_mie = 1'b1;
        mie = 3'b111;
        mip = 3'b011;
        mret_s1 = 1'b1;
        tick("irq_mret_take", taken(32'h80000003, 32'd0));
        clear_flags();
        tick("irq_mret_idle", idle(32'h80000003, 32'd0));

        // plain mret: one cycle of return
        mret_s1 = 1'b1;
        tick("mret_ret", returning(32'h80000003));
        mret_s1 = 1'b0;
        tick("mret_idle", idle(32'h80000003, 32'd0));

        // global enable off: exceptions still trap, interrupts do not
        mstatus_mie = 1'b0;
        mip = 3'b111;
        ebreak_s1 = 1'b1;
        single_trap("masked_ebreak", 32'h3);

        // only MTIE enabled: timer interrupt beats a misaligned fetch
        mstatus_mie = 1'b1;
        mie = 3'b010;
        mip = 3'b111;
        misaligned_instruction_s1 = 1'b1;
        single_trap("mti", 32'h80000007);

        // synchronous exception priorities
        mstatus_mie = 1'b0;
        misaligned_instruction_s1 = 1'b1;
        illegal_instruction_s1 = 1'b1;
        ecall_s1 = 1'b1;
        single_trap("prio_fetch", 32'h0);
        ebreak_s1 = 1'b1;
        ecall_s1 = 1'b1;
        misaligned_load_s1 = 1'b1;
        single_trap("prio_ebreak", 32'h3);
        ecall_s1 = 1'b1;
        misaligned_store_s1 = 1'b1;
        single_trap("prio_ecall", 32'hB);
        misaligned_load_s1 = 1'b1;
        misaligned_store_s1 = 1'b1;
        single_trap("prio_load", 32'h4);
        misaligned_store_s1 = 1'b1;
        single_trap("prio_store", 32'h6);

        // external interrupt in vectored mode
        mstatus_mie = 1'b1;
        mie = 3'b111;
        mip = 3'b111;
        mtvec_mode = 1'b1;
        tick("mei_take", taken(32'h8000000B, VEC_MEI));
        clear_flags();
        tick("mei_idle", idle(32'h8000000B, VEC_MEI));
        mtvec_mode = 1'b0;
        #1;
        sample_now("mei_direct", idle(32'h8000000B, 32'd0));

        // interrupt withdrawn during drain is still committed
        mie = 3'b010;
        mip = 3'b010;
        bus_busy = 1'b1;
        tick("irq_wait1", waiting(32'h80000007));
        mip = 3'b000;
        tick("irq_wait2", waiting(32'h80000007));
        bus_busy = 1'b0;
        tick("irq_take", taken(32'h80000007, 32'd0));
        tick("irq_idle", idle(32'h80000007, 32'd0));

        // reset during TRAP_WAIT discards the captured cause
        mstatus_mie = 1'b0;
        illegal_instruction_s1 = 1'b1;
        bus_busy = 1'b1;
        tick("rstw_wait", waiting(32'h2));
        illegal_instruction_s1 = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        sample_now("rstw_async", boot());
        bus_busy = 1'b0;
        tick("rstw_hold", boot());
        reset = 1'b0;
        tick("rstw_oper", idle(32'd0, 32'd0));
        tick("rstw_no_trap", idle(32'd0, 32'd0));

        check_eq("sb_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rvx_core_trap_sequencer.md
Name: rvx_core_trap_sequencer

Overview:
- Sequences the core's control-flow exceptions.
- Consumes per-instruction trap/return flags from the stage-1 decoder, plus interrupt-pending state from the CSR file.
- Selects trap cause and priority, waits for outstanding memory traffic to drain, then drives the PC mux, pipeline flush/stall and CSR trap-entry/return strobes.
- Sits between decoder, CSR file and fetch PC mux.

Parameters:
- BOOT_ADDRESS, 32'h00000000, PC loaded on the first cycle after reset.

Ports:
- clock  input  1  core clock
- reset  input  1  asynchronous, active-high reset
- illegal_instruction_s1  input  1  decoder: illegal encoding
- ecall_s1  input  1  decoder: ECALL
- ebreak_s1  input  1  decoder: EBREAK
- mret_s1  input  1  decoder: MRET
- misaligned_instruction_s1  input  1  fetch address misaligned
- misaligned_load_s1  input  1  load address misaligned
- misaligned_store_s1  input  1  store address misaligned
- mstatus_mie  input  1  global interrupt enable
- mie  input  3  {MEIE,MTIE,MSIE} enables
- mip  input  3  {MEIP,MTIP,MSIP} pending
- bus_busy  input  1  memory transaction outstanding
- mtvec_mode  input  1  0 = direct, 1 = vectored (used only with the optional feature)
- pc_mux_sel  output  2  00 next, 01 trap vector, 10 mepc, 11 boot
- flush_s1  output  1  squash instruction in stage 1
- stall_s1  output  1  hold stage 1 and fetch
- trap_taken  output  1  CSR: write mepc/mcause, MPIE<=MIE, MIE<=0
- mret_taken  output  1  CSR: MIE<=MPIE, MPIE<=1
- mcause  output  32  registered cause {interrupt bit, 27'b0, code[3:0]}
- trap_vector_offset  output  32  offset added to mtvec base

Behaviour:
- States: RESET, OPERATING, TRAP_WAIT, TRAP_TAKEN, TRAP_RETURN. Encodings are 3 bits.
- Reset asynchronously enters RESET; mcause = 0; all strobes = 0. This applies mid-operation too: any pending captured cause is discarded.
- RESET (1 cycle):
  - pc_mux_sel = 11, flush_s1 = 1.
  - Next state is OPERATING.
- OPERATING: irq = mstatus_mie & |(mie & mip).
- Event priority, highest first:
  - irq, with code MEI 11 > MSI 3 > MTI 7
  - misaligned_instruction (0)
  - illegal (2)
  - ebreak (3)
  - ecall (11)
  - misaligned_load (4)
  - misaligned_store (6)
  - mret
- Any trap event: mcause is registered at the clock edge, with bit31 = irq.
  - bus_busy = 1: next state is TRAP_WAIT.
  - Otherwise: next state is TRAP_TAKEN.
- mret with no trap event: next state is TRAP_RETURN. Concurrent irq wins; the mret is discarded and its PC becomes mepc.
- No event: pc_mux_sel = 00, all strobes 0.
- TRAP_WAIT:
  - stall_s1 = 1 and mcause is held.
  - Stays until bus_busy = 0, then goes to TRAP_TAKEN.
  - Deassertion of the interrupt while waiting does not cancel the trap; the cause is committed.
- TRAP_TAKEN (1 cycle):
  - trap_taken = 1, pc_mux_sel = 01, flush_s1 = 1.
  - Decoder flags are ignored.
  - Next state is OPERATING.
- TRAP_RETURN (1 cycle):
  - mret_taken = 1, pc_mux_sel = 10, flush_s1 = 1.
  - Next state is OPERATING.
- Latency: trap event at edge N produces trap_taken in cycle N+1 (no drain), or in the first cycle after bus_busy falls.
- stall_s1 and flush_s1 are never both 1.
- All outputs are combinational from state plus registered mcause.

Optional Feature:
- Macro: RVX_TRAP_VECTORED_EN.
- Defined: trap_vector_offset = {26'b0, mcause[3:0], 2'b00} when mcause[31] = 1 and mtvec_mode = 1; otherwise 0.
- Undefined: trap_vector_offset tied to 0 and mtvec_mode ignored. Ports are unchanged.

Decomposition:
- rvx_constants.vh holds:
  - cause codes (RVX_CAUSE_*)
  - PC mux encodings (RVX_PC_NEXT/TRAP/MEPC/BOOT)
  - state encodings (RVX_TRAP_STATE_*)
- One combinational sub-module, rvx_core_interrupt_prioritizer: mie/mip/mstatus_mie in; irq flag and 4-bit code out.

Test Plan:
- Reset release → one cycle of pc_mux_sel = 11 and flush_s1 = 1, then pc_mux_sel = 00; mcause = 0.
- illegal_instruction_s1 = 1, bus_busy = 0 → next cycle trap_taken = 1, pc_mux_sel = 01, mcause = 32'h00000002.
- ecall_s1 = 1 with bus_busy = 1 for 3 cycles → stall_s1 = 1 for 3 cycles, then trap_taken with mcause = 32'h0000000B; the ecall is not lost.
- mstatus_mie = 1, mie = 3'b111, mip = 3'b011 (MTIP + MSIP) coincident with mret_s1 → trap_taken, mcause = 32'h80000003, mret_taken never asserted.
- mret_s1 alone → mret_taken = 1, pc_mux_sel = 10, flush_s1 = 1 for exactly one cycle.
- With RVX_TRAP_VECTORED_EN and mtvec_mode = 1, MEIP taken → trap_vector_offset = 32'h2C. Assert reset during TRAP_WAIT → immediate RESET, mcause = 0, and no trap_taken afterwards.
